fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Multi-cycle instruction sequencer for the 8-bit accumulator machine. It produces the opcode that the control unit decodes.
- Owns the PC and the instruction register. Drives the single shared (von Neumann) memory address: PC during fetch, accumulator during the LW/SW data phase.
- Emits a one-cycle execute strobe that gates the decoder's regWE/memWE/accWE, so each instruction commits exactly once.

Parameters:
- ADDR_W, 8, PC and memory address width.
- RESET_PC, 8'h00, PC value after reset.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  1 = sequence instructions; sampled in IDLE and at instruction boundaries.
- mem_rdata  in  8  memory read data; valid the cycle after mem_addr is presented (synchronous-read memory).
- acc_val  in  8  current accumulator value; used as data address and as branch target.
- br_cond  in  1  ALU "!= 0" result; sampled in EXEC of BNZ.
- mem_addr  out  ADDR_W  shared memory address.
- pc  out  ADDR_W  current PC.
- opcode  out  3  inst_r[7:5], to the control unit.
- operand  out  5  inst_r[4:0] (immediate / register field).
- exec_en  out  1  commit strobe; downstream write enables are ANDed with it.
- mem_phase  out  1  1 while mem_addr is sourced from acc_val.
- busy  out  1  1 in any state other than IDLE.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, inst_r=8'h00, retired=0, exec_en=0, mem_phase=0, busy=0, mem_addr=RESET_PC.
- States: IDLE, FETCH, LATCH, EXEC, MEMACC, MEMWB. All outputs except mem_addr are registered. mem_addr is a combinational mux of pc / acc_val selected by state.
- IDLE: mem_addr=pc. run=1 -> FETCH, else stay.
- FETCH: mem_addr=pc -> LATCH.
- LATCH: inst_r <= mem_rdata -> EXEC.
- EXEC, opcodes 000–101 (ACM, ACMI, ADD, NAND, BNZ, SLT):
  - exec_en=1 for exactly this cycle.
  - Next pc: BNZ and br_cond=1 -> pc<=acc_val; otherwise pc<=pc+1 (mod 2^ADDR_W, 8'hFF wraps to 8'h00).
  - retired+1 (wraps at 2^CNT_W).
  - Next state: FETCH if run=1, else IDLE.
- EXEC, opcode 110 (SW): exec_en=0, pc<=pc+1 -> MEMACC.
- EXEC, opcode 111 (LW): exec_en=0, pc<=pc+1 -> MEMACC.
- MEMACC:
  - mem_addr=acc_val, mem_phase=1.
  - SW: exec_en=1 (memory writes this cycle), retired+1, then FETCH/IDLE per run.
  - LW: exec_en=0 -> MEMWB.
- MEMWB (LW only): mem_phase=1, mem_addr=acc_val, exec_en=1 (RF captures mem_rdata), retired+1, then FETCH/IDLE per run.
- Latency, FETCH to commit strobe inclusive:
  - non-memory instruction: 3 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
- run=0 mid-instruction: the current instruction completes, then the sequencer goes to IDLE. There is no abort.
- run toggling while in IDLE only is allowed; pc is retained.
- Reset mid-instruction: immediate return to reset values. No partial commit, because exec_en is forced 0 asynchronously.
- BNZ with br_cond=0: pc+1. The branch target is acc_val latched on the EXEC edge.
- exec_en is never high for two consecutive cycles.
- mem_phase=1 only in MEMACC and MEMWB.

Test Plan:
- Reset, then run=1, memory[0]=8'h25 (ACMI 5) -> FETCH/LATCH/EXEC. opcode=001, operand=5, exec_en pulses in cycle 3, pc=1, retired=1.
- SW at pc=3, acc_val=8'h40 -> in MEMACC mem_addr=8'h40, mem_phase=1, exec_en=1. Next FETCH mem_addr=8'h04, retired+1.
- LW at pc=7, acc_val=8'h80, memory[0x80]=8'h5A -> exec_en low in EXEC and MEMACC, high in MEMWB with mem_rdata=8'h5A, mem_addr=8'h80. Total 5 cycles.
- BNZ with br_cond=1, acc_val=8'h10 -> pc=8'h10. With br_cond=0 at pc=8'hFF -> pc wraps to 8'h00.
- run dropped during LATCH of an ADD -> ADD still commits (one exec_en), then IDLE with busy=0 and pc retained. run=1 resumes at the next pc.
- rst_n asserted during MEMACC of SW -> exec_en=0 immediately, state=IDLE, pc=RESET_PC, retired=0. No write strobe is observed.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction sequencer for the 8-bit accumulator machine: owns PC and
// instruction register, steers the shared memory address and issues one commit strobe per instruction.
module fetch_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [7:0]        mem_rdata,
  input  logic [7:0]        acc_val,
  input  logic              br_cond,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        opcode,
  output logic [4:0]        operand,
  output logic              exec_en,
  output logic              mem_phase,
  output logic              busy,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EXEC,
    S_MEMACC,
    S_MEMWB
  } state_t;

  localparam logic [2:0] OP_BNZ = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b110;
  localparam logic [2:0] OP_LW  = 3'b111;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [7:0]         r_inst;
  logic [CNT_W-1:0]   r_retired;
  logic               r_exec_en;
  logic               r_mem_phase;
  logic               r_busy;

  logic [2:0]         w_opcode;
  logic               w_is_mem;
  logic               w_commit;
  logic               w_data_phase;
  logic [ADDR_W-1:0]  w_acc_addr;

  assign w_opcode     = r_inst[7:5];
  assign w_is_mem     = (w_opcode == OP_SW) || (w_opcode == OP_LW);
  assign w_acc_addr   = ADDR_W'(acc_val);
  assign w_data_phase = (r_state == S_MEMACC) || (r_state == S_MEMWB);

  // The cycle in which an instruction retires; exec_en is high in exactly these cycles.
  assign w_commit = ((r_state == S_EXEC)   && !w_is_mem)              ||
                    ((r_state == S_MEMACC) && (w_opcode == OP_SW))    ||
                    (r_state == S_MEMWB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_inst      <= '0;
      r_retired   <= '0;
      r_exec_en   <= 1'b0;
      r_mem_phase <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // NOTE: this default makes exec_en a one-cycle pulse; later non-blocking writes
      // in the same block override it only in the cycle before a commit state.
      r_exec_en <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: r_state <= S_LATCH;
        S_LATCH: begin
          r_inst    <= mem_rdata;
          r_state   <= S_EXEC;
          r_exec_en <= (mem_rdata[7:6] != 2'b11);
        end
        S_EXEC: begin
          if ((w_opcode == OP_BNZ) && br_cond) r_pc <= w_acc_addr;
          else                                 r_pc <= r_pc + ADDR_W'(1);
          if (w_is_mem) begin
            r_state     <= S_MEMACC;
            r_mem_phase <= 1'b1;
            r_exec_en   <= (w_opcode == OP_SW);
          end
        end
        S_MEMACC: begin
          if (w_opcode == OP_LW) begin
            r_state   <= S_MEMWB;
            r_exec_en <= 1'b1;
          end
        end
        S_MEMWB: ;
        default: r_state <= S_IDLE;
      endcase

      if (w_commit) begin
        r_retired   <= r_retired + CNT_W'(1);
        r_mem_phase <= 1'b0;
        r_busy      <= run;
        r_state     <= run ? S_FETCH : S_IDLE;
      end
    end
  end

  assign mem_addr  = w_data_phase ? w_acc_addr : r_pc;
  assign pc        = r_pc;
  assign opcode    = r_inst[7:5];
  assign operand   = r_inst[4:0];
  assign exec_en   = r_exec_en;
  assign mem_phase = r_mem_phase;
  assign busy      = r_busy;
  assign retired   = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed instruction table, hand-written run/reset corner
// sequences, then random programs checked against an instruction-level reference model.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [7:0]  mem_rdata;
  logic [7:0]  acc_val;
  logic        br_cond;
  logic [7:0]  mem_addr;
  logic [7:0]  pc;
  logic [2:0]  opcode;
  logic [4:0]  operand;
  logic        exec_en;
  logic        mem_phase;
  logic        busy;
  logic [15:0] retired;

  int vec_count  = 0;
  int miscompares = 0;

  logic [7:0] mem [256];

  fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'h00), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mem_rdata(mem_rdata), .acc_val(acc_val),
    .br_cond(br_cond), .mem_addr(mem_addr), .pc(pc), .opcode(opcode), .operand(operand),
    .exec_en(exec_en), .mem_phase(mem_phase), .busy(busy), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: data for the address presented this cycle appears next cycle.
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] addr;
    logic [7:0] inst;
    logic [7:0] acc;
    logic       br;
    logic [2:0] op;
    logic [4:0] opnd;
    int         lat;
    logic [7:0] caddr;
    logic       mph;
    logic [7:0] npc;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    run     = 1'b0;
    acc_val = 8'h00;
    br_cond = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Entered in the FETCH cycle of the vector's instruction with run=1.
  task automatic apply_vec(input vec_t v, input int idx);
    int n;
    check("vec_fetch_addr", mem_addr, v.addr);
    acc_val = v.acc;
    br_cond = v.br;
    n = 1;
    while (!exec_en && n < 8) begin
      step();
      n++;
    end
    check("vec_latency", n, v.lat);
    check("vec_opcode", opcode, v.op);
    check("vec_operand", operand, v.opnd);
    check("vec_commit_addr", mem_addr, v.caddr);
    check("vec_mem_phase", mem_phase, v.mph);
    if (v.lat == 5) check("vec_lw_rdata", mem_rdata, mem[v.acc]);
    step();
    check("vec_no_double_strobe", exec_en, 1'b0);
    check("vec_next_pc", pc, v.npc);
    check("vec_retired", retired, idx + 1);
  endtask

  // Reference model state: architectural PC and retired count.
  logic [7:0]  m_pc;
  logic [15:0] m_ret;

  // Entered in the FETCH cycle; checks every cycle of one instruction from the
  // latency rules (3 / 4 / 5 cycles), then applies its architectural effect.
  task automatic do_inst(input logic keep_run);
    logic [7:0] inst, acc, pc_inc;
    logic [2:0] op;
    logic       br;
    int         lat;
    inst   = mem[m_pc];
    op     = inst[7:5];
    lat    = (op == 3'b110) ? 4 : (op == 3'b111) ? 5 : 3;
    acc    = 8'($urandom);
    br     = 1'($urandom);
    pc_inc = m_pc + 8'd1;
    acc_val = acc;
    br_cond = br;
    run     = keep_run;
    check("rnd_retired", retired, m_ret);
    for (int k = 1; k <= lat; k++) begin
      check("rnd_busy", busy, 1'b1);
      check("rnd_exec_en", exec_en, (k == lat));
      check("rnd_mem_phase", mem_phase, (k >= 4));
      check("rnd_mem_addr", mem_addr, (k >= 4) ? acc : m_pc);
      check("rnd_pc", pc, (k >= 4) ? pc_inc : m_pc);
      if (k >= 3) begin
        check("rnd_opcode", opcode, op);
        check("rnd_operand", operand, inst[4:0]);
      end
      if (k == 5) check("rnd_lw_rdata", mem_rdata, mem[acc]);
      if (k < lat) step();
    end
    m_pc  = ((op == 3'b100) && br) ? acc : pc_inc;
    m_ret = m_ret + 16'd1;
    step();
    if (!keep_run) begin
      for (int j = 0; j <= int'($urandom_range(0, 2)); j++) begin
        check("rnd_idle_busy", busy, 1'b0);
        check("rnd_idle_exec_en", exec_en, 1'b0);
        check("rnd_idle_pc", pc, m_pc);
        check("rnd_idle_retired", retired, m_ret);
        step();
      end
      run = 1'b1;
      step();
    end
  endtask

  initial begin
    vecs[0]  = '{8'h00, 8'h25, 8'h00, 1'b0, 3'd1, 5'd5,  3, 8'h00, 1'b0, 8'h01};
    vecs[1]  = '{8'h01, 8'h4C, 8'h00, 1'b0, 3'd2, 5'd12, 3, 8'h01, 1'b0, 8'h02};
    vecs[2]  = '{8'h02, 8'h61, 8'h00, 1'b0, 3'd3, 5'd1,  3, 8'h02, 1'b0, 8'h03};
    vecs[3]  = '{8'h03, 8'hC0, 8'h40, 1'b0, 3'd6, 5'd0,  4, 8'h40, 1'b1, 8'h04};
    vecs[4]  = '{8'h04, 8'h0F, 8'h00, 1'b0, 3'd0, 5'd15, 3, 8'h04, 1'b0, 8'h05};
    vecs[5]  = '{8'h05, 8'hA3, 8'h00, 1'b0, 3'd5, 5'd3,  3, 8'h05, 1'b0, 8'h06};
    vecs[6]  = '{8'h06, 8'h80, 8'h33, 1'b0, 3'd4, 5'd0,  3, 8'h06, 1'b0, 8'h07};
    vecs[7]  = '{8'h07, 8'hE2, 8'h80, 1'b0, 3'd7, 5'd2,  5, 8'h80, 1'b1, 8'h08};
    vecs[8]  = '{8'h08, 8'h81, 8'h10, 1'b1, 3'd4, 5'd1,  3, 8'h08, 1'b0, 8'h10};
    vecs[9]  = '{8'h10, 8'h82, 8'hFF, 1'b1, 3'd4, 5'd2,  3, 8'h10, 1'b0, 8'hFF};
    vecs[10] = '{8'hFF, 8'h9F, 8'h22, 1'b0, 3'd4, 5'd31, 3, 8'hFF, 1'b0, 8'h00};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 11; i++) mem[vecs[i].addr] = vecs[i].inst;
    mem[8'h80] = 8'h5A;

    // Reset state
    rst_n   = 1'b0;
    run     = 1'b0;
    acc_val = 8'h00;
    br_cond = 1'b0;
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_exec_en", exec_en, 1'b0);
    check("rst_mem_phase", mem_phase, 1'b0);
    check("rst_pc", pc, 8'h00);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_retired", retired, 16'h0000);
    check("rst_opcode", opcode, 3'b000);
    check("rst_operand", operand, 5'h00);
    rst_n = 1'b1;
    step();
    check("idle_busy", busy, 1'b0);

    // Directed table, run held high throughout
    run = 1'b1;
    step();
    for (int i = 0; i < 11; i++) apply_vec(vecs[i], i);

    // run dropped during LATCH of an ADD: ADD still commits once, then IDLE
    do_reset();
    mem[8'h00] = 8'h43;
    mem[8'h01] = 8'h25;
    run = 1'b1;
    step();
    check("drop_fetch_busy", busy, 1'b1);
    check("drop_fetch_addr", mem_addr, 8'h00);
    step();
    run = 1'b0;
    step();
    check("drop_exec_en", exec_en, 1'b1);
    check("drop_opcode", opcode, 3'd2);
    step();
    for (int j = 0; j < 3; j++) begin
      check("drop_idle_busy", busy, 1'b0);
      check("drop_idle_exec_en", exec_en, 1'b0);
      check("drop_idle_pc", pc, 8'h01);
      check("drop_idle_retired", retired, 16'd1);
      step();
    end
    run = 1'b1;
    step();
    check("resume_busy", busy, 1'b1);
    check("resume_addr", mem_addr, 8'h01);
    step();
    step();
    check("resume_exec_en", exec_en, 1'b1);
    check("resume_opcode", opcode, 3'd1);
    step();
    check("resume_pc", pc, 8'h02);
    check("resume_retired", retired, 16'd2);

    // Reset asserted during MEMACC of SW
    do_reset();
    mem[8'h00] = 8'hC0;
    acc_val = 8'h40;
    run = 1'b1;
    step();
    step();
    step();
    check("swrst_exec_low", exec_en, 1'b0);
    step();
    check("swrst_memacc_phase", mem_phase, 1'b1);
    check("swrst_memacc_addr", mem_addr, 8'h40);
    rst_n = 1'b0;
    #1;
    check("swrst_exec_en", exec_en, 1'b0);
    check("swrst_busy", busy, 1'b0);
    check("swrst_pc", pc, 8'h00);
    check("swrst_retired", retired, 16'd0);
    check("swrst_mem_phase", mem_phase, 1'b0);
    check("swrst_mem_addr", mem_addr, 8'h00);
    for (int j = 0; j < 2; j++) begin
      step();
      check("swrst_hold_exec_en", exec_en, 1'b0);
    end
    run = 1'b0;
    rst_n = 1'b1;
    step();
    check("swrst_after_busy", busy, 1'b0);
    check("swrst_after_retired", retired, 16'd0);

    // Random programs against the instruction-level model
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    m_pc  = 8'h00;
    m_ret = 16'd0;
    run = 1'b1;
    step();
    for (int n = 0; n < 300; n++) do_inst($urandom_range(0, 9) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
